reaction_timer_multi: RTL
=========================

Name: reaction_timer_multi

Overview:
- Parametrised N-player reaction timer. A start press arms a round, a pseudo-random delay elapses, then the stimulus LED lights and the first player press is timed in milliseconds.
- Adds per-player false-start detection, deterministic tie-break, timeout and per-round result registers.
- Sits between the button inputs and the display/LED drivers in the top level. Display encoding happens downstream.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency. CLK_HZ/1000 must be at least 2.
- N_PLAYERS, 4: number of player buttons, 2..16.
- TIME_W, 14: width of the millisecond result.
- MIN_DELAY_MS, 1000: fixed part of the arm-to-stimulus delay.
- RAND_BITS, 11: LFSR bits added to the delay (0..2^RAND_BITS-1 ms).
- TIMEOUT_MS, 9999: reaction limit. Must be < 2^TIME_W.

Ports:
- clk  in  1  system clock.
- ck_rst  in  1  asynchronous, active-high reset.
- start  in  1  start/re-arm button, asynchronous level.
- btn  in  N_PLAYERS  player buttons, asynchronous level.
- arm_led  out  1  high while waiting for the stimulus.
- stim_led  out  1  stimulus, high while timing.
- player_led  out  N_PLAYERS  winner one-hot, or false-start mask.
- winner_id  out  PID_W  winning player index; PID_W = max(1, clog2(N_PLAYERS)).
- time_ms  out  TIME_W  latched reaction time.
- tie  out  1  two or more players pressed in the winning cycle.
- false_start  out  1  round aborted by an early press.
- timeout  out  1  no press within TIMEOUT_MS.
- done  out  1  one-cycle pulse on entry to RESULT, FAULT or TIMEOUT.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Prescaler 0, ms counter 0.
  - LFSR = 16'hACE1.
  - Synchroniser flops 0.
- Reset mid-round returns to IDLE immediately; no pending event survives.
- Input path:
  - start and every btn bit pass through a 2-flop synchroniser, then a rising-edge register.
  - An input that goes high before clk edge k is acted on at edge k+3.
  - Held buttons generate one edge only.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clock and is never zero.
- ms tick:
  - Prescaler counts 0..CLK_HZ/1000-1; the tick fires on the terminal count.
  - Prescaler clears on entry to ARMED and to GO.
- States:
  - IDLE: all LEDs off. start edge -> ARMED.
  - ARMED:
    - On entry, clear result outputs, player_led, tie and flags.
    - On entry, load delay = MIN_DELAY_MS + LFSR[RAND_BITS-1:0].
    - arm_led=1; delay decrements per tick.
    - Any btn edge -> FAULT; this has priority over delay expiry in the same cycle.
    - Delay reaching 0 -> GO.
  - GO:
    - stim_led=1, arm_led=0; ms counter starts at 0 and increments per tick.
    - First cycle with any btn edge -> RESULT:
      - winner_id = lowest-index pressed bit; player_led = one-hot(winner_id).
      - time_ms = ms counter value; tie = popcount(edges) > 1.
    - ms counter reaching TIMEOUT_MS with no edge -> TIMEOUT: time_ms = TIMEOUT_MS, timeout=1, player_led=0.
    - A press in the same cycle as timeout wins (RESULT).
  - FAULT:
    - false_start=1; player_led = mask of all btn edges in the triggering cycle.
    - winner_id=0; time_ms=0; stim_led never asserts.
  - RESULT / FAULT / TIMEOUT:
    - LEDs and results hold; further btn edges are ignored.
    - start edge -> ARMED (new round).
- start edges in ARMED or GO are ignored.
- done pulses for exactly one cycle on entry to RESULT, FAULT or TIMEOUT.

Optional Feature:
- Macro: BEST_TIME_EN.
- Defined:
  - Adds outputs best_ms (TIME_W) and best_id (PID_W), reset to all-ones and 0.
  - On each RESULT, if time_ms < best_ms, update both in the same edge as time_ms. Ties keep the earlier record.
  - FAULT and TIMEOUT never update them. Only ck_rst clears them.
- Undefined: the ports and logic are absent.

Test Plan (CLK_HZ=100_000, i.e. 100 clk/ms; N_PLAYERS=4; MIN_DELAY_MS=10; RAND_BITS=4; TIMEOUT_MS=50):
- Reset, then start pulse -> all outputs 0 during reset; arm_led=1 at edge 3 after start; stim_led rises 1000..2500 clks later with arm_led=0.
- btn[2] high 700 clks after stim_led rose -> winner_id=2, player_led=4'b0100, time_ms=7, tie=0, done high one cycle, stim_led held.
- btn[1] and btn[3] rise in the same cycle during GO -> winner_id=1, player_led=4'b0010, tie=1.
- btn[0] pressed during ARMED -> false_start=1, player_led=4'b0001, stim_led stays 0 for 5000 clks; next start -> ARMED with false_start cleared.
- No press after stimulus -> after 5000 clks timeout=1, time_ms=50, player_led=0; ck_rst pulsed mid-GO in a later round -> all outputs 0 asynchronously, IDLE.
- BEST_TIME_EN: rounds won at 7 ms (player 2) then 4 ms (player 0), then a false start -> best_ms=4, best_id=0 unchanged after the fault.

Source files
------------

// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi: N-player reaction timer with false-start, tie-break and timeout detection.
// Optional best-time record (best_ms/best_id) is built when BEST_TIME_EN is defined.

module reaction_timer_multi #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int N_PLAYERS    = 4,
  parameter int TIME_W       = 14,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int TIMEOUT_MS   = 9999,
  localparam int PID_W       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 ck_rst,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] btn,
  output logic                 arm_led,
  output logic                 stim_led,
  output logic [N_PLAYERS-1:0] player_led,
  output logic [PID_W-1:0]     winner_id,
  output logic [TIME_W-1:0]    time_ms,
  output logic                 tie,
  output logic                 false_start,
  output logic                 timeout,
`ifdef BEST_TIME_EN
  output logic [TIME_W-1:0]    best_ms,
  output logic [PID_W-1:0]     best_id,
`endif
  output logic                 done
);

  localparam int PRESC_N = CLK_HZ / 1000;
  localparam int PRESC_W = $clog2(PRESC_N);
  localparam int DLY_W   = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);
  localparam int IN_W    = N_PLAYERS + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_FAULT  = 3'd4,
    S_TMO    = 3'd5
  } state_t;

  state_t state_r, next_state;

  logic [IN_W-1:0]      in_s1_r, in_s2_r, in_s3_r, edge_r;
  logic [PRESC_W-1:0]   presc_r;
  logic [15:0]          lfsr_r;
  logic [DLY_W-1:0]     delay_r;
  logic [TIME_W-1:0]    ms_r;
  logic                 start_edge_s;
  logic [N_PLAYERS-1:0] btn_edge_s;
  logic                 any_btn_s;
  logic                 tick_s;
  logic                 enter_s;

  // Galois step for x^16+x^14+x^13+x^11+1; a non-zero seed never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Lowest set index gives a deterministic winner when presses coincide.
  function automatic logic [PID_W-1:0] lowest_idx(input logic [N_PLAYERS-1:0] v);
    lowest_idx = {PID_W{1'b0}};
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = PID_W'(i);
    end
  endfunction

  function automatic logic multi_hot(input logic [N_PLAYERS-1:0] v);
    multi_hot = (v & (v - N_PLAYERS'(1))) != {N_PLAYERS{1'b0}};
  endfunction

  assign start_edge_s = edge_r[N_PLAYERS];
  assign btn_edge_s   = edge_r[N_PLAYERS-1:0];
  assign any_btn_s    = |btn_edge_s;
  assign tick_s       = (presc_r == PRESC_W'(PRESC_N - 1));
  assign enter_s      = (next_state != state_r);

  // Two-flop synchroniser followed by a registered rising-edge detector; start is the top bit.
  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      in_s1_r <= {IN_W{1'b0}};
      in_s2_r <= {IN_W{1'b0}};
      in_s3_r <= {IN_W{1'b0}};
      edge_r  <= {IN_W{1'b0}};
    end else begin
      in_s1_r <= {start, btn};
      in_s2_r <= in_s1_r;
      in_s3_r <= in_s2_r;
      edge_r  <= in_s2_r & ~in_s3_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) state_r <= S_IDLE;
    else        state_r <= next_state;
  end

  // Next-state logic; a press beats delay expiry in ARMED and beats timeout in GO.
  always_comb begin
    next_state = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_edge_s) next_state = S_ARMED;
        else              next_state = state_r;
      end
      S_ARMED: begin
        if (any_btn_s)                              next_state = S_FAULT;
        else if (tick_s && delay_r <= DLY_W'(1))    next_state = S_GO;
        else                                        next_state = state_r;
      end
      S_GO: begin
        if (any_btn_s)                                          next_state = S_RESULT;
        else if (tick_s && ms_r == TIME_W'(TIMEOUT_MS - 1))     next_state = S_TMO;
        else                                                    next_state = state_r;
      end
      S_RESULT, S_FAULT, S_TMO: begin
        if (start_edge_s) next_state = S_ARMED;
        else              next_state = state_r;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Prescaler, LFSR, delay/ms counters and the registered result outputs.
  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      presc_r     <= {PRESC_W{1'b0}};
      lfsr_r      <= 16'hACE1;
      delay_r     <= {DLY_W{1'b0}};
      ms_r        <= {TIME_W{1'b0}};
      arm_led     <= 1'b0;
      stim_led    <= 1'b0;
      player_led  <= {N_PLAYERS{1'b0}};
      winner_id   <= {PID_W{1'b0}};
      time_ms     <= {TIME_W{1'b0}};
      tie         <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
      done        <= 1'b0;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
      done   <= enter_s && (next_state == S_RESULT || next_state == S_FAULT || next_state == S_TMO);
      if (enter_s && (next_state == S_ARMED || next_state == S_GO)) presc_r <= {PRESC_W{1'b0}};
      else if (tick_s)                                               presc_r <= {PRESC_W{1'b0}};
      else                                                           presc_r <= presc_r + PRESC_W'(1);
      if (enter_s) begin
        case (next_state)
          S_ARMED: begin
            delay_r     <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_r[RAND_BITS-1:0]);
            arm_led     <= 1'b1;
            stim_led    <= 1'b0;
            player_led  <= {N_PLAYERS{1'b0}};
            winner_id   <= {PID_W{1'b0}};
            time_ms     <= {TIME_W{1'b0}};
            tie         <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
          end
          S_GO: begin
            arm_led  <= 1'b0;
            stim_led <= 1'b1;
            ms_r     <= {TIME_W{1'b0}};
          end
          S_RESULT: begin
            winner_id  <= lowest_idx(btn_edge_s);
            player_led <= {{(N_PLAYERS-1){1'b0}}, 1'b1} << lowest_idx(btn_edge_s);
            time_ms    <= ms_r;
            tie        <= multi_hot(btn_edge_s);
          end
          S_FAULT: begin
            arm_led     <= 1'b0;
            false_start <= 1'b1;
            player_led  <= btn_edge_s;
            winner_id   <= {PID_W{1'b0}};
            time_ms     <= {TIME_W{1'b0}};
          end
          S_TMO: begin
            time_ms    <= TIME_W'(TIMEOUT_MS);
            timeout    <= 1'b1;
            player_led <= {N_PLAYERS{1'b0}};
          end
          default: begin
            arm_led  <= 1'b0;
            stim_led <= 1'b0;
          end
        endcase
      end else if (tick_s) begin
        if (state_r == S_ARMED)   delay_r <= delay_r - DLY_W'(1);
        else if (state_r == S_GO) ms_r    <= ms_r + TIME_W'(1);
      end
    end
  end

`ifdef BEST_TIME_EN
  // Best-time record; strictly faster wins so an equal time keeps the earlier holder.
  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      best_ms <= {TIME_W{1'b1}};
      best_id <= {PID_W{1'b0}};
    end else if (enter_s && next_state == S_RESULT && ms_r < best_ms) begin
      best_ms <= ms_r;
      best_id <= lowest_idx(btn_edge_s);
    end
  end
`endif

endmodule
